// File: rtl/dmem_read_arbiter_pkg.sv
// Shared types and constants for the data-memory read-port arbiter.
// Owner tag and FSM state encodings live here so RTL and bench agree.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 13;
    localparam int DMEM_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_CP
    } owner_t;

    typedef enum logic {
        ST_ARB,
        ST_LOCK
    } state_t;

    // Round-robin tie break: CPU wins unless it won the previous grant.
    function automatic logic rr_cpu_wins(input owner_t last);
        return last != OWN_CPU;
    endfunction

endpackage

// File: rtl/dmem_read_arbiter_if.sv
// Read-port bundle between the two readers, the arbiter and the bsram.
// slave: arbiter side; master: requesters plus memory side.
interface dmem_read_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int DATA_WIDTH = DMEM_DATA_W
);

    logic                  cpu_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  cp_req;
    logic [ADDR_WIDTH-1:0] cp_addr;
    logic                  cp_lock;
    logic                  cp_gnt;
    logic                  cp_rvalid;
    logic [DATA_WIDTH-1:0] cp_rdata;

    logic [ADDR_WIDTH-1:0] mem_dout_addr;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  cpu_req,
        input  cpu_addr,
        output cpu_gnt,
        output cpu_rvalid,
        output cpu_rdata,
        input  cp_req,
        input  cp_addr,
        input  cp_lock,
        output cp_gnt,
        output cp_rvalid,
        output cp_rdata,
        output mem_dout_addr,
        input  mem_dout
    );

    modport master (
        output cpu_req,
        output cpu_addr,
        input  cpu_gnt,
        input  cpu_rvalid,
        input  cpu_rdata,
        output cp_req,
        output cp_addr,
        output cp_lock,
        input  cp_gnt,
        input  cp_rvalid,
        input  cp_rdata,
        input  mem_dout_addr,
        output mem_dout
    );

endinterface

// File: rtl/dmem_read_arbiter_starve.sv
// Saturating count of consecutive denied CPU cycles; hit_o at LIMIT.
// Only compiled in builds with DMEM_ARB_STARVE_GUARD_EN defined.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    output logic hit_o
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (inc_i) begin
            cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == LIM);

endmodule
`endif

// File: rtl/dmem_read_arbiter.sv
// Shares the bsram read port between CPU loads and the rect copier.
// Optional CPU anti-starvation grant: DMEM_ARB_STARVE_GUARD_EN.
module dmem_read_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DMEM_ADDR_W,
    parameter int DATA_WIDTH   = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    dmem_read_arbiter_if.slave  bus
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be >= 1");
    end

    state_t                state_q, state_d;
    owner_t                own_q, own_d;
    owner_t                last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic cpu_g;
    logic cp_g;
    logic arb_mode;
    logic force_cpu;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic starve_hit;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (bus.cpu_req && !cpu_g),
        .hit_o (starve_hit)
    );

    assign force_cpu = starve_hit && bus.cpu_req;
`else
    assign force_cpu = 1'b0;
`endif

    // Lock release is honoured in the same cycle cp_lock falls.
    assign arb_mode = (state_q == ST_ARB) || !bus.cp_lock;

    always_comb begin
        cpu_g = 1'b0;
        cp_g  = 1'b0;
        if (!reset) begin
            cpu_g = 1'b0;
        end else if (force_cpu) begin
            cpu_g = 1'b1;
        end else if (!arb_mode) begin
            cp_g = bus.cp_req;
        end else if (bus.cpu_req && bus.cp_req) begin
            cpu_g = rr_cpu_wins(last_q);
            cp_g  = !rr_cpu_wins(last_q);
        end else begin
            cpu_g = bus.cpu_req;
            cp_g  = bus.cp_req;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = OWN_NONE;
        last_d  = last_q;
        addr_d  = addr_q;
        if (arb_mode) begin
            state_d = (cp_g && bus.cp_lock) ? ST_LOCK : ST_ARB;
        end
        if (cpu_g) begin
            own_d  = OWN_CPU;
            last_d = OWN_CPU;
            addr_d = bus.cpu_addr;
        end else if (cp_g) begin
            own_d  = OWN_CP;
            last_d = OWN_CP;
            addr_d = bus.cp_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
            own_q   <= OWN_NONE;
            last_q  <= OWN_CP;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.cpu_gnt       = cpu_g;
    assign bus.cp_gnt        = cp_g;
    assign bus.mem_dout_addr = addr_d;

    assign bus.cpu_rvalid = (own_q == OWN_CPU);
    assign bus.cp_rvalid  = (own_q == OWN_CP);
    assign bus.cpu_rdata  = (own_q == OWN_CPU) ? bus.mem_dout : '0;
    assign bus.cp_rdata   = (own_q == OWN_CP) ? bus.mem_dout : '0;

endmodule

// File: tb/tb_dmem_read_arbiter.sv
// Bench for dmem_read_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the arbitration rules.
module tb_dmem_read_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW  = DMEM_ADDR_W;
    localparam int DW  = DMEM_DATA_W;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dmem_read_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) bus.mem_dout <= mem[bus.mem_dout_addr];

    int checks = 0;
    int errors = 0;

    // model state
    bit            m_locked;
    bit            m_cpu_next;
    int            m_starve;
    int            m_owner;
    logic [AW-1:0] m_held;
    logic [AW-1:0] m_rd_addr;
    bit            e_cpu_gnt;
    bit            e_cp_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic cq, input logic [AW-1:0] ca,
                        input logic pq, input logic [AW-1:0] pa, input logic pl);
        bit ec, ep, fc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ecd, epd;
        @(negedge clk);
        reset        = rn;
        bus.cpu_req  = cq;
        bus.cpu_addr = ca;
        bus.cp_req   = pq;
        bus.cp_addr  = pa;
        bus.cp_lock  = pl;
        #1;
        if (!rn) begin
            m_locked   = 0;
            m_cpu_next = 1;
            m_starve   = 0;
            m_owner    = 0;
            m_held     = '0;
        end
`ifdef DMEM_ARB_STARVE_GUARD_EN
        fc = cq && (m_starve == LIM);
`else
        fc = 0;
`endif
        ec = 0;
        ep = 0;
        if (rn) begin
            if (fc) ec = 1;
            else if (m_locked && pl) ep = pq;
            else if (cq && pq) begin
                ec = m_cpu_next;
                ep = !m_cpu_next;
            end else begin
                ec = cq;
                ep = pq;
            end
        end
        ea  = ec ? ca : (ep ? pa : m_held);
        ecd = (m_owner == 1) ? mem[m_rd_addr] : '0;
        epd = (m_owner == 2) ? mem[m_rd_addr] : '0;
        chk("cpu_gnt", bus.cpu_gnt, ec);
        chk("cp_gnt", bus.cp_gnt, ep);
        chk("mem_dout_addr", bus.mem_dout_addr, ea);
        chk("cpu_rvalid", bus.cpu_rvalid, m_owner == 1);
        chk("cp_rvalid", bus.cp_rvalid, m_owner == 2);
        chk("cpu_rdata", bus.cpu_rdata, ecd);
        chk("cp_rdata", bus.cp_rdata, epd);
        e_cpu_gnt = ec;
        e_cp_gnt  = ep;
        if (rn) begin
            if (ec || ep) m_cpu_next = ep;
            if (!(m_locked && pl)) m_locked = ep && pl;
            m_owner   = ec ? 1 : (ep ? 2 : 0);
            m_rd_addr = ea;
            m_held    = ea;
            if (cq && !ec) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            else m_starve = 0;
        end
    endtask

    initial begin
        bit            cq, pq, pl;
        logic [AW-1:0] ca, pa;
        reset        = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.cp_req   = 1'b0;
        bus.cp_addr  = '0;
        bus.cp_lock  = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        mem[13'h010] = 16'hBEEF;

        // 1: reset holds everything low, CPU wins first tie
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom), 1'($urandom));
            chk("t1_rst_gnt", {bus.cpu_gnt, bus.cp_gnt}, 0);
            chk("t1_rst_rv", {bus.cpu_rvalid, bus.cp_rvalid}, 0);
            chk("t1_rst_rd", {bus.cpu_rdata, bus.cp_rdata}, 0);
        end
        step(1, 1, 13'h111, 1, 13'h222, 0);
        chk("t1_first_tie", {bus.cpu_gnt, bus.cp_gnt}, 2'b10);

        // 2: single CPU read
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 13'h010, 0, 0, 0);
        chk("t2_gnt", bus.cpu_gnt, 1);
        chk("t2_addr", bus.mem_dout_addr, 13'h010);
        step(1, 0, 0, 0, 0, 0);
        chk("t2_rvalid", bus.cpu_rvalid, 1);
        chk("t2_rdata", bus.cpu_rdata, 16'hBEEF);
        chk("t2_hold_addr", bus.mem_dout_addr, 13'h010);

        // 3: round robin
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 13'h020, 1, 13'h030, 0);
            chk("t3_cpu_gnt", bus.cpu_gnt, (i % 2) == 0);
            chk("t3_cp_gnt", bus.cp_gnt, (i % 2) == 1);
            chk("t3_addr", bus.mem_dout_addr, (i % 2) ? 13'h030 : 13'h020);
        end

        // 4/5: copier lock with CPU waiting
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 13'h100, 1);
        chk("t4_lock_gnt", bus.cp_gnt, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 13'h040, 1, AW'(13'h101 + i), 1);
`ifdef DMEM_ARB_STARVE_GUARD_EN
            chk("t5_cpu_gnt", bus.cpu_gnt, (i % 9) == 8);
            chk("t5_cp_gnt", bus.cp_gnt, (i % 9) != 8);
`else
            chk("t4_cpu_gnt", bus.cpu_gnt, 0);
            chk("t4_cp_gnt", bus.cp_gnt, 1);
`endif
        end
        step(1, 1, 13'h040, 1, 13'h200, 0);
        chk("t4_release", {bus.cpu_gnt, bus.cp_gnt}, 2'b10);

        // 6: reset right after a locked copier grant
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 13'h050, 1);
        chk("t6_cp_gnt", bus.cp_gnt, 1);
        step(0, 1, 13'h060, 1, 13'h070, 1);
        chk("t6_no_stale", bus.cp_rvalid, 0);
        step(1, 1, 13'h060, 1, 13'h070, 0);
        chk("t6_cpu_first", {bus.cpu_gnt, bus.cp_gnt}, 2'b10);
        step(1, 0, 0, 1, 13'h070, 0);
        chk("t6_arb_state", bus.cp_gnt, 1);

        // random traffic
        cq = 0; ca = '0; pl = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!cq) begin
                cq = ($urandom_range(0, 2) != 0);
                ca = AW'($urandom);
            end
            pq = ($urandom_range(0, 3) != 0);
            pa = AW'($urandom);
            if ($urandom_range(0, 11) == 0) pl = !pl;
            step(($urandom_range(0, 299) != 0), cq, ca, pq, pa, pl);
            if (e_cpu_gnt || !reset) cq = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
